// File: rtl/mux_pkg.sv
// Shared constants for the 16:1 selector tree, plus a sel-to-lane helper
// that scoreboards can use to index the packed input.
package mux_pkg;

    localparam int N_IN  = 16;
    localparam int SEL_W = 4;
    localparam int GRP   = 4;

    function automatic int lane_index(input logic [SEL_W-1:0] sel);
        return int'(sel);
    endfunction

endpackage

// File: rtl/mux4_to_1.sv
// Purely combinational 4:1 multiplexer; an X on s merges the data inputs
// bitwise so unknowns stay visible in simulation.
module mux4_to_1 #(
    parameter int DATA_W = 1
) (
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    input  logic [1:0]        s,
    output logic [DATA_W-1:0] y
);

    assign y = (s == 2'd0) ? d0 :
               (s == 2'd1) ? d1 :
               (s == 2'd2) ? d2 : d3;

endmodule

// File: rtl/mux16_to_1_using_4_to_1.sv
// Registered 16:1 lane selector: four 4:1 muxes pick within each nibble group,
// a fifth picks among the groups, and the result is registered once.
module mux16_to_1_using_4_to_1
    import mux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN*DATA_W-1:0]   in,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic [DATA_W-1:0]        out,
    output logic                     out_valid
);

    // Handshake: in_valid qualifies in/sel on the rising edge it is sampled;
    // there is no ready, so a new sample is accepted every cycle, and
    // out_valid marks the cycle in which out carries that sample.

    logic [DATA_W-1:0] grp_y [GRP];
    logic [DATA_W-1:0] out_next;

    for (genvar g = 0; g < GRP; g++) begin : g_level1
        mux4_to_1 #(.DATA_W(DATA_W)) u_mux (
            .d0 (in[(GRP*g + 0)*DATA_W +: DATA_W]),
            .d1 (in[(GRP*g + 1)*DATA_W +: DATA_W]),
            .d2 (in[(GRP*g + 2)*DATA_W +: DATA_W]),
            .d3 (in[(GRP*g + 3)*DATA_W +: DATA_W]),
            .s  (sel[1:0]),
            .y  (grp_y[g])
        );
    end

    mux4_to_1 #(.DATA_W(DATA_W)) u_level2 (
        .d0 (grp_y[0]),
        .d1 (grp_y[1]),
        .d2 (grp_y[2]),
        .d3 (grp_y[3]),
        .s  (sel[3:2]),
        .y  (out_next)
    );

    // out only loads on valid samples so it holds across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= out_next;
            end
        end
    end

endmodule

// File: tb/tb_mux16_to_1_using_4_to_1.sv
// Bench for the registered 16:1 selector at lane widths 1 and 8, checked
// against a lane-array reference model kept in the bench.
module tb_mux16_to_1_using_4_to_1;
    import mux_pkg::*;

    logic         clk;
    logic         rst;
    logic [3:0]   sel;
    logic         in_valid;
    logic [15:0]  in1;
    logic [127:0] in8;
    logic         out1;
    logic         out_valid1;
    logic [7:0]   out8;
    logic         out_valid8;

    int n_checks = 0;
    int n_fail   = 0;

    logic         exp1;
    logic [7:0]   exp8;
    logic         exp_v;
    logic [7:0]   exp_q[$];

    mux16_to_1_using_4_to_1 #(.DATA_W(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in        (in1),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out1),
        .out_valid (out_valid1)
    );

    mux16_to_1_using_4_to_1 #(.DATA_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in        (in8),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out8),
        .out_valid (out_valid8)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

    // ---------------- driver + reference model ----------------
    function automatic logic [127:0] wide_lanes();
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = 8'h10 + 8'(k);
        return v;
    endfunction

    task automatic drive(input logic [3:0] s, input logic [15:0] d1,
                         input logic [127:0] d8, input logic v);
        @(negedge clk);
        sel      = s;
        in1      = d1;
        in8      = d8;
        in_valid = v;
        @(posedge clk);
        if (!rst) begin
            exp_v = v;
            if (v) begin
                exp1 = d1[lane_index(s)];
                exp8 = d8[lane_index(s)*8 +: 8];
            end
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; sel = 4'd0; in1 = 16'h3f0d; in8 = wide_lanes(); in_valid = 1'b0;
        exp1 = 1'b0; exp8 = 8'h00; exp_v = 1'b0;
        #1;
        n_checks++;
        if (out1 !== 1'b0 || out_valid1 !== 1'b0 || out8 !== 8'h00 || out_valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: out1=%b ov1=%b out8=%h ov8=%b expected all 0",
                     out1, out_valid1, out8, out_valid8);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        drive(4'h0, 16'h3f0d, wide_lanes(), 1'b1);
        n_checks++;
        if (out1 !== 1'b1 || out_valid1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preload: out1=%b ov1=%b expected 1 1", out1, out_valid1);
        end

        // Assert reset between edges: outputs must clear before the next edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp1 = 1'b0; exp8 = 8'h00; exp_v = 1'b0;
        n_checks++;
        if (out1 !== 1'b0 || out_valid1 !== 1'b0 || out8 !== 8'h00 || out_valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: out1=%b ov1=%b out8=%h ov8=%b expected all 0",
                     out1, out_valid1, out8, out_valid8);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out1 !== 1'b0 || out_valid1 !== 1'b0 || out8 !== 8'h00 || out_valid8 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold edge %0d: out1=%b ov1=%b out8=%h ov8=%b expected all 0",
                         i, out1, out_valid1, out8, out_valid8);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        drive(4'h0, 16'h3f0d, wide_lanes(), 1'b1);
        n_checks++;
        if (out1 !== 1'b1 || out_valid1 !== 1'b1 || out8 !== 8'h10) begin
            n_fail++;
            $display("FAIL reset_release: out1=%b ov1=%b out8=%h expected 1 1 10",
                     out1, out_valid1, out8);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] sels [8];
        logic       want [8];
        sels = '{4'h0, 4'hb, 4'hf, 4'h2, 4'hd, 4'h9, 4'h7, 4'ha};
        want = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(sels[i], 16'h3f0d, wide_lanes(), 1'b1);
            n_checks++;
            if (out1 !== want[i] || out_valid1 !== 1'b1 || out8 !== 8'h10 + 8'(sels[i])) begin
                n_fail++;
                $display("FAIL sweep sel=%h: out1=%b ov1=%b out8=%h expected %b 1 %h",
                         sels[i], out1, out_valid1, out8, want[i], 8'h10 + 8'(sels[i]));
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [15:0] onehot;
        for (int s = 0; s < 16; s++) begin
            onehot = 16'h0001 << s;
            drive(4'(s), onehot, wide_lanes(), 1'b1);
            n_checks++;
            if (out1 !== 1'b1) begin
                n_fail++;
                $display("FAIL exhaustive_onehot sel=%0d: out1=%b expected 1", s, out1);
            end
            drive(4'(s), ~onehot, wide_lanes(), 1'b1);
            n_checks++;
            if (out1 !== 1'b0) begin
                n_fail++;
                $display("FAIL exhaustive_inverse sel=%0d: out1=%b expected 0", s, out1);
            end
        end
    endtask

    task automatic test_hold();
        drive(4'h0, 16'h3f0d, wide_lanes(), 1'b1);
        n_checks++;
        if (out1 !== 1'b1 || out_valid1 !== 1'b1 || out8 !== 8'h10) begin
            n_fail++;
            $display("FAIL hold_load: out1=%b ov1=%b out8=%h expected 1 1 10", out1, out_valid1, out8);
        end
        drive(4'hf, 16'h3f0d, wide_lanes(), 1'b0);
        n_checks++;
        if (out1 !== 1'b1 || out_valid1 !== 1'b0 || out8 !== 8'h10 || out_valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_idle: out1=%b ov1=%b out8=%h ov8=%b expected 1 0 10 0",
                     out1, out_valid1, out8, out_valid8);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back((i % 2 == 0) ? 8'h01 : 8'h00);
            drive(4'(i % 2), 16'h3f0d, wide_lanes(), 1'b1);
            want = exp_q.pop_front();
            n_checks++;
            if (out1 !== want[0] || out_valid1 !== 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: out1=%b ov1=%b expected %b 1",
                         i, out1, out_valid1, want[0]);
            end
        end
    endtask

    task automatic test_wide_random();
        logic [127:0] d8;
        logic [15:0]  d1;
        logic         v;
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 4; k++) d8[k*32 +: 32] = $urandom;
            d1 = 16'($urandom);
            v  = 1'($urandom_range(0, 3) != 0);
            drive(4'($urandom_range(0, 15)), d1, d8, v);
            n_checks++;
            if (out1 !== exp1 || out8 !== exp8 || out_valid1 !== exp_v || out_valid8 !== exp_v) begin
                n_fail++;
                $display("FAIL random cycle %0d: out1=%b out8=%h ov1=%b ov8=%b expected %b %h %b",
                         i, out1, out8, out_valid1, out_valid8, exp1, exp8, exp_v);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_sweep();
        test_exhaustive();
        test_hold();
        test_back_to_back();
        test_wide_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
